fetch_prefetch: RTL and testbench

Parametrised instruction-fetch front end for the BEAN RISC-V core. It owns the fetch PC, issues sequential word requests to instruction memory over a valid/ready channel, and buffers in-order responses in a DEPTH-entry prefetch queue. It presents {pc, instruction} pairs to decode. Branch/jump redirects flush all queued and in-flight work.

---
 rtl/bean_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_prefetch.sv | 112 +++++++++++
 tb/tb_fetch_prefetch.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bean_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bean_pkg
//  Description : Shared core-wide widths, reset vector and fetch constants
//                for the BEAN RISC-V core.
//  Revision    : 1.0 - initial release
// ============================================================================
package bean_pkg;

  localparam int          XPR_LEN  = 32;
  localparam int          ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0200;
  localparam int          PC_STEP  = 4;

  typedef logic [ILEN-1:0] inst_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO holding {pc, instruction} pairs between
//                the memory response port and decode. Registered storage,
//                no write-to-read bypass; flush empties it in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A flush overrides both ports; popping an empty queue is ignored.
  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && (r_count != '0);

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch
//  Description : Instruction-fetch front end. Owns the fetch PC, issues
//                sequential word requests under a credit limit, buffers
//                in-order responses with their PCs and presents them to
//                decode. Redirects flush queued work and mark in-flight
//                requests as stale so their responses are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
  parameter int                 XPR_LEN  = bean_pkg::XPR_LEN,
  parameter int                 ILEN     = bean_pkg::ILEN,
  parameter int                 DEPTH    = 4,
  parameter logic [XPR_LEN-1:0] RESET_PC = bean_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XPR_LEN-1:0] redirect_pc,
  output logic               imem_req_valid,
  output logic [XPR_LEN-1:0] imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [ILEN-1:0]    imem_resp_data,
  output logic               inst_valid,
  output logic [XPR_LEN-1:0] inst_pc,
  output logic [ILEN-1:0]    inst_data,
  input  logic               inst_ready
);

  import bean_pkg::*;

  localparam int                     c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [XPR_LEN-1:0]     c_step  = XPR_LEN'(PC_STEP);
  localparam logic [c_cnt_w:0]       c_limit = (c_cnt_w+1)'(DEPTH);

  logic [XPR_LEN-1:0]      r_fetch_pc;
  logic [c_cnt_w-1:0]      r_live;
  logic [c_cnt_w-1:0]      r_drop;
  logic [c_cnt_w-1:0]      w_count;
  logic [c_cnt_w:0]        w_occ_queue;
  logic [c_cnt_w:0]        w_occ_mem;
  logic                    w_req_fire;
  logic                    w_resp_keep;
  logic                    w_resp_stale;
  logic                    w_push;
  logic                    w_pop;
  logic [XPR_LEN-1:0]      w_resp_pc;
  logic [XPR_LEN+ILEN-1:0] w_head;
  logic                    w_unused;

  // Low target bits are forced to zero, so they carry no information.
  assign w_unused = ^redirect_pc[1:0];

  // Credits: queue slots must cover every live request, and the memory
  // never holds more than DEPTH outstanding requests (live plus stale).
  assign w_occ_queue    = {1'b0, w_count} + {1'b0, r_live};
  assign w_occ_mem      = {1'b0, r_live}  + {1'b0, r_drop};
  assign imem_req_valid = !rst && !redirect_valid &&
                          (w_occ_queue < c_limit) && (w_occ_mem < c_limit);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Stale responses are consumed first; only fresh ones enter the queue.
  assign w_resp_stale = imem_resp_valid && (r_drop != '0);
  assign w_resp_keep  = imem_resp_valid && (r_drop == '0);
  assign w_push       = w_resp_keep && !redirect_valid;

  // Live requests are a contiguous sequential run ending just below
  // fetch_pc, so the oldest one (the one answering now) sits live words back.
  assign w_resp_pc = r_fetch_pc - (XPR_LEN'(r_live) * c_step);

  assign inst_valid = (w_count != '0) && !redirect_valid;
  assign w_pop      = inst_valid && inst_ready;
  assign {inst_pc, inst_data} = w_head;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XPR_LEN + ILEN)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({w_resp_pc, imem_resp_data}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count)
  );

  // Fetch PC and the live/stale request counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XPR_LEN-1:2], 2'b00};
      r_drop     <= r_drop + r_live - c_cnt_w'(imem_resp_valid);
      r_live     <= '0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + c_step;
      end
      r_live <= r_live + c_cnt_w'(w_req_fire) - c_cnt_w'(w_resp_keep);
      r_drop <= r_drop - c_cnt_w'(w_resp_stale);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch
//  Description : Self-checking bench for fetch_prefetch with an in-order
//                variable-latency memory model and a stream-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  always #5 clk = ~clk;

  fetch_prefetch #(
    .XPR_LEN  (32),
    .ILEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data),
    .inst_ready      (inst_ready)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;
  int          fires = 0;
  int          pops = 0;
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_out = RST_PC;
  logic [31:0] last_fire_addr = '0;
  logic [31:0] last_pop_pc = '0;

  // Memory contents: a scrambled function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Drive the memory side for the current cycle, let outputs settle, then
  // check the visible stream against the reference ordering.
  task automatic settle();
    int lat;
    int due;
    if (rst) begin
      pend.delete();
      last_due = cyc;
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend[0].data;
      pend.delete(0);
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (rst || redirect_valid) begin
      vectors++;
      if (imem_req_valid !== 1'b0)
        $display("FAIL req_blocked: imem_req_valid=%b expected 0 (cyc %0d)", imem_req_valid, cyc);
      if (imem_req_valid !== 1'b0) miscompares++;
    end
    if (redirect_valid) begin
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL inst_valid_on_redirect: got %b expected 0 (cyc %0d)", inst_valid, cyc);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      vectors++;
      if (imem_req_addr !== exp_req) begin
        miscompares++;
        $display("FAIL req_addr: got %h expected %h (cyc %0d)", imem_req_addr, exp_req, cyc);
      end
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{data: mem_word(imem_req_addr), due: due});
      vectors++;
      if (pend.size() > DEPTH) begin
        miscompares++;
        $display("FAIL outstanding: got %0d expected <= %0d (cyc %0d)", pend.size(), DEPTH, cyc);
      end
      exp_req        = exp_req + 32'd4;
      fires++;
      last_fire_addr = imem_req_addr;
    end
    if (inst_valid && inst_ready) begin
      vectors++;
      if (inst_pc !== exp_out || inst_data !== mem_word(exp_out)) begin
        miscompares++;
        $display("FAIL pop: got pc %h data %h expected pc %h data %h (cyc %0d)",
                 inst_pc, inst_data, exp_out, mem_word(exp_out), cyc);
      end
      exp_out     = exp_out + 32'd4;
      pops++;
      last_pop_pc = inst_pc;
    end
    if (rst) begin
      exp_req = RST_PC;
      exp_out = RST_PC;
    end else if (redirect_valid) begin
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_out = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_pop(input int p0, input string name);
    for (int i = 0; i < 40 && pops == p0; i++) step();
    vectors++;
    if (pops == p0) begin
      miscompares++;
      $display("FAIL %s_timeout: got no instruction expected one within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    step();
    settle();
    vectors += 3;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    if (inst_data !== 32'h0) begin miscompares++; $display("FAIL reset_inst_data: got %h expected 0", inst_data); end
    tick();
    rst = 1'b0;
    settle();
    vectors += 2;
    if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    if (imem_req_addr !== RST_PC) begin miscompares++; $display("FAIL first_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
    tick();
  endtask

  task automatic test_sequential();
    int f0, p0;
    do_reset();
    inst_ready = 1'b1; ready_pct = 100; lat_min = 1; lat_max = 1;
    f0 = fires; p0 = pops;
    repeat (12) step();
    vectors += 3;
    if (fires - f0 != 12) begin miscompares++; $display("FAIL seq_requests: got %0d expected 12", fires - f0); end
    if (pops - p0 != 10) begin miscompares++; $display("FAIL seq_pops: got %0d expected 10", pops - p0); end
    if (last_pop_pc !== 32'h0000_0224) begin miscompares++; $display("FAIL seq_last_pc: got %h expected 00000224", last_pop_pc); end
  endtask

  task automatic test_credit();
    int f0;
    do_reset();
    inst_ready = 1'b0; ready_pct = 100; lat_min = 3; lat_max = 3;
    f0 = fires;
    repeat (10) step();
    vectors++;
    if (fires - f0 != DEPTH) begin miscompares++; $display("FAIL credit_requests: got %0d expected %0d", fires - f0, DEPTH); end
    inst_ready = 1'b1;
    settle();
    vectors += 2;
    if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL credit_full_req: got %b expected 0", imem_req_valid); end
    if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL credit_full_valid: got %b expected 1", inst_valid); end
    tick();
    inst_ready = 1'b0;
    repeat (8) step();
    settle();
    vectors += 2;
    if (fires - f0 != DEPTH + 1) begin miscompares++; $display("FAIL credit_one_more: got %0d expected %0d", fires - f0, DEPTH + 1); end
    if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL credit_refull_req: got %b expected 0", imem_req_valid); end
    tick();
  endtask

  task automatic test_redirect_drop();
    int p0;
    do_reset();
    inst_ready = 1'b1; ready_pct = 100; lat_min = 4; lat_max = 4;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_1000) begin
      miscompares++;
      $display("FAIL drop_new_req: got valid %b addr %h expected 1 00001000", imem_req_valid, imem_req_addr);
    end
    tick();
    p0 = pops;
    wait_pop(p0, "drop");
    vectors++;
    if (last_pop_pc !== 32'h0000_1000) begin miscompares++; $display("FAIL drop_first_pc: got %h expected 00001000", last_pop_pc); end
  endtask

  task automatic test_redirect_resp();
    int p0;
    do_reset();
    inst_ready = 1'b0; ready_pct = 100; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !(pend.size() > 0 && pend[0].due <= cyc && inst_valid); i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000; inst_ready = 1'b1;
    settle();
    vectors++;
    if (imem_resp_valid !== 1'b1) begin miscompares++; $display("FAIL coinc_setup: got resp %b expected 1", imem_resp_valid); end
    tick();
    redirect_valid = 1'b0;
    settle();
    vectors++;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL coinc_empty: got inst_valid %b expected 0", inst_valid); end
    tick();
    p0 = pops;
    wait_pop(p0, "coinc");
    vectors++;
    if (last_pop_pc !== 32'h0000_3000) begin miscompares++; $display("FAIL coinc_first_pc: got %h expected 00003000", last_pop_pc); end
  endtask

  task automatic test_wrap();
    int f0, p0;
    do_reset();
    inst_ready = 1'b1; ready_pct = 100; lat_min = 1; lat_max = 3;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    settle();
    tick();
    redirect_valid = 1'b0;
    f0 = fires; p0 = pops;
    for (int i = 0; i < 20 && fires < f0 + 3; i++) step();
    vectors++;
    if (fires < f0 + 3 || last_fire_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_req: got %0d reqs last %h expected 3 reqs last 00000000", fires - f0, last_fire_addr);
    end
    for (int i = 0; i < 30 && pops < p0 + 3; i++) step();
    vectors++;
    if (pops < p0 + 3 || last_pop_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pop: got %0d pops last %h expected 3 pops last 00000000", pops - p0, last_pop_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 1'b0; ready_pct = 100; lat_min = 3; lat_max = 3;
    repeat (5) step();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    settle();
    vectors += 3;
    if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", inst_valid); end
    if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_pc: got %h expected 0", inst_pc); end
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL midrst_req: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    lat_min = 1; lat_max = 5; ready_pct = 70;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(999) < 3);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = $urandom;
      inst_ready     = ($urandom_range(99) < 60);
      step();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    vectors++;
    if (pops - p0 < 200) begin miscompares++; $display("FAIL random_progress: got %0d pops expected >= 200", pops - p0); end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_credit();
    test_redirect_drop();
    test_redirect_resp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
